// File: rtl/sd_spi_responder.sv
// SD card SPI-mode responder: decodes 48-bit command frames and answers CMD0/CMD1/CMD17 with R1 and a 512-byte block.
// Latency: R1 follows one 0xFF byte after the frame; block data follows NAC_BYTES fill bytes and a 0xFE token.
// Backpressure: none; the host paces every bit through sclk, and cs_n high aborts to HUNT at once.
module sd_spi_responder #(
    parameter int NAC_BYTES = 2,
    parameter int CMD1_BUSY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        card_ready,
    output logic [8:0]  mem_addr,
    input  logic [7:0]  mem_data
);

    typedef enum logic [2:0] {HUNT, CMD, NCR, R1, NAC, TOKEN, DATA, CRC} state_t;

    localparam logic [7:0] C1_LIM   = 8'(CMD1_BUSY);
    localparam logic [8:0] NAC_LAST = 9'(NAC_BYTES - 1);

    state_t      state, state_nxt;
    logic        sclk_q;
    logic        rise, fall;
    // Holds the previously received frame bits; bit j is frame bit j+1 when the last bit arrives.
    logic [44:0] rx_sr;
    logic [5:0]  rx_cnt;
    logic [2:0]  bit_cnt;
    logic [8:0]  byte_cnt;
    logic [7:0]  r1_val;
    logic [7:0]  c1_cnt;
    logic        go_data;
    logic [7:0]  tx_byte;
    logic        byte_done;
    logic        hunt_hit;
    logic        frame_done;

    assign rise       = sclk & ~sclk_q;
    assign fall       = ~sclk & sclk_q;
    assign byte_done  = rise && (bit_cnt == 3'd7);
    assign hunt_hit   = (rx_sr[0] == 1'b0) && mosi;
    assign frame_done = (state == CMD) && rise && (rx_cnt == 6'd47);

    // Registered copy of sclk for edge detection; follows sclk even in reset so no phantom edge appears on release.
    always_ff @(posedge clk) begin
        sclk_q <= sclk;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= HUNT;
        else      state <= state_nxt;
    end

    // Next-state: byte-granular sequencing of the response, cs_n high forces HUNT.
    always_comb begin
        state_nxt = state;
        if (cs_n) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT:  if (rise && hunt_hit) state_nxt = CMD;
                CMD:   if (frame_done) state_nxt = NCR;
                NCR:   if (byte_done) state_nxt = R1;
                R1:    if (byte_done) state_nxt = go_data ? ((NAC_BYTES > 0) ? NAC : TOKEN) : HUNT;
                NAC:   if (byte_done && byte_cnt == NAC_LAST) state_nxt = TOKEN;
                TOKEN: if (byte_done) state_nxt = DATA;
                DATA:  if (byte_done && byte_cnt == 9'd511) state_nxt = CRC;
                CRC:   if (byte_done && byte_cnt == 9'd1) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Output: byte currently being shifted out in each transmit state.
    always_comb begin
        tx_byte = 8'hFF;
        case (state)
            R1:      tx_byte = r1_val;
            TOKEN:   tx_byte = 8'hFE;
            DATA:    tx_byte = mem_data;
            default: tx_byte = 8'hFF;
        endcase
    end

    // Datapath: frame capture, R1 decision, bit/byte counting, block address and miso shifting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            miso       <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_index  <= 6'd0;
            cmd_arg    <= 32'd0;
            card_ready <= 1'b0;
            mem_addr   <= 9'd0;
            c1_cnt     <= 8'd0;
            rx_sr      <= '1;
            rx_cnt     <= 6'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 9'd0;
            r1_val     <= 8'h00;
            go_data    <= 1'b0;
        end else if (cs_n) begin
            miso      <= 1'b1;
            cmd_valid <= 1'b0;
            rx_sr     <= '1;
            rx_cnt    <= 6'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 9'd0;
        end else begin
            cmd_valid <= 1'b0;
            if (state == HUNT || state == CMD) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 9'd0;
            end
            if (rise) begin
                case (state)
                    HUNT: begin
                        rx_sr <= {rx_sr[43:0], mosi};
                        if (hunt_hit) rx_cnt <= 6'd2;
                    end
                    CMD: begin
                        if (rx_cnt == 6'd47) begin
                            // Last bit (stop bit) of the frame: the CRC byte is simply discarded.
                            cmd_valid <= 1'b1;
                            cmd_index <= rx_sr[44:39];
                            cmd_arg   <= rx_sr[38:7];
                            rx_sr     <= '1;
                            rx_cnt    <= 6'd0;
                            go_data   <= 1'b0;
                            case (rx_sr[44:39])
                                6'd0: begin
                                    r1_val     <= 8'h01;
                                    card_ready <= 1'b0;
                                    c1_cnt     <= 8'd0;
                                end
                                6'd1: begin
                                    if (c1_cnt < C1_LIM) begin
                                        r1_val <= 8'h01;
                                        c1_cnt <= c1_cnt + 8'd1;
                                    end else begin
                                        r1_val     <= 8'h00;
                                        card_ready <= 1'b1;
                                    end
                                end
                                6'd17: begin
                                    r1_val  <= card_ready ? 8'h00 : 8'h05;
                                    go_data <= card_ready;
                                end
                                default: r1_val <= {7'b0000010, ~card_ready};
                            endcase
                        end else begin
                            rx_sr  <= {rx_sr[43:0], mosi};
                            rx_cnt <= rx_cnt + 6'd1;
                        end
                    end
                    default: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            byte_cnt <= (state_nxt != state) ? 9'd0 : byte_cnt + 9'd1;
                            // Address moves on the byte boundary so the read settles before the next falling edge.
                            if (state_nxt == TOKEN)  mem_addr <= 9'd0;
                            else if (state == DATA)  mem_addr <= mem_addr + 9'd1;
                        end
                    end
                endcase
            end
            if (fall) miso <= (state == HUNT || state == CMD) ? 1'b1 : tx_byte[~bit_cnt];
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
`timescale 1ns/1ps
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        card_ready;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data = 8'h00;

    int          checks = 0;
    int          errors = 0;
    int          vld_cnt = 0;
    logic [511:0] addr_seen;
    logic        trk_clr;
    logic [7:0]  exp_q[$];
    string       tag;

    always #5 clk = ~clk;

    sd_spi_responder #(.NAC_BYTES(2), .CMD1_BUSY(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .card_ready(card_ready), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Block memory model: byte k holds k mod 256, one clk read latency.
    always @(posedge clk) mem_data <= mem_addr[7:0];

    // Counts clk cycles with cmd_valid high.
    always @(posedge clk) if (cmd_valid) vld_cnt <= vld_cnt + 1;

    // Records which block addresses were presented.
    always @(posedge clk) begin
        if (trk_clr) addr_seen <= '0;
        else         addr_seen[mem_addr] <= 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    // One host byte in SPI mode 0 (2 clk low, 2 clk high per bit); the received byte is checked against the scoreboard.
    task automatic xfer(input logic [7:0] tx);
        logic [7:0] rx;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (2) @(negedge clk);
            sclk  = 1'b1;
            rx[i] = miso;
            repeat (2) @(negedge clk);
            sclk = 1'b0;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: got %02h expected nothing queued", tag, rx);
        end else begin
            e = exp_q.pop_front();
            assert (rx === e) else begin
                errors++;
                $error("FAIL %s: got %02h expected %02h", tag, rx, e);
            end
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] b[6];
        b[0] = {2'b01, idx};
        b[1] = arg[31:24];
        b[2] = arg[23:16];
        b[3] = arg[15:8];
        b[4] = arg[7:0];
        b[5] = crc;
        for (int i = 0; i < 6; i++) begin
            push(8'hFF);
            xfer(b[i]);
        end
    endtask

    task automatic rx_n(input int n);
        for (int i = 0; i < n; i++) xfer(8'hFF);
    endtask

    task automatic cmd1_x3;
        for (int i = 0; i < 3; i++) begin
            send_cmd(6'd1, 32'd0, 8'hFF);
            push(8'hFF);
            push((i < 2) ? 8'h01 : 8'h00);
            rx_n(2);
            chk("cmd1_ready", card_ready, (i == 2) ? 1 : 0);
        end
    endtask

    initial begin
        int v0;
        rst = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b1; trk_clr = 1'b1;
        tag = "reset";
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_index", cmd_index, 0);
        chk("rst_cmd_arg", cmd_arg, 0);
        chk("rst_card_ready", card_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);

        // CMD0
        tag = "cmd0";
        v0 = vld_cnt;
        send_cmd(6'd0, 32'd0, 8'h95);
        chk("cmd0_valid_pulse", vld_cnt - v0, 1);
        chk("cmd0_index", cmd_index, 0);
        push(8'hFF); push(8'h01);
        rx_n(2);
        chk("cmd0_ready", card_ready, 0);

        // CMD1 until ready
        tag = "cmd1";
        cmd1_x3();
        chk("cmd1_index", cmd_index, 1);

        // CMD17 full block read
        tag = "cmd17";
        trk_clr = 1'b0;
        v0 = vld_cnt;
        send_cmd(6'd17, 32'd3, 8'hFF);
        chk("cmd17_valid_pulse", vld_cnt - v0, 1);
        chk("cmd17_index", cmd_index, 17);
        chk("cmd17_arg", cmd_arg, 3);
        push(8'hFF); push(8'h00); push(8'hFF); push(8'hFF); push(8'hFE);
        for (int k = 0; k < 512; k++) push(8'(k));
        push(8'hFF); push(8'hFF); push(8'hFF);
        rx_n(520);
        chk("cmd17_addr_cover", &addr_seen, 1);
        chk("cmd17_miso_idle", miso, 1);

        // Other command while ready
        tag = "cmd55_ready";
        send_cmd(6'd55, 32'd0, 8'hFF);
        push(8'hFF); push(8'h04);
        rx_n(2);

        // CMD17 without initialisation
        tag = "cmd17_idle";
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_cmd(6'd17, 32'd0, 8'hFF);
        push(8'hFF); push(8'h05);
        for (int k = 0; k < 8; k++) push(8'hFF);
        rx_n(10);
        tag = "cmd8_idle";
        send_cmd(6'd8, 32'h1AA, 8'h87);
        push(8'hFF); push(8'h05);
        rx_n(2);

        // Abort mid-DATA with cs_n
        tag = "abort_setup";
        send_cmd(6'd0, 32'd0, 8'h95);
        push(8'hFF); push(8'h01);
        rx_n(2);
        cmd1_x3();
        tag = "abort_read";
        send_cmd(6'd17, 32'd0, 8'hFF);
        push(8'hFF); push(8'h00); push(8'hFF); push(8'hFF); push(8'hFE);
        for (int k = 0; k < 101; k++) push(8'(k));
        rx_n(106);
        chk("abort_pre_miso", miso, 0);
        cs_n = 1'b1;
        @(negedge clk);
        chk("abort_miso", miso, 1);
        chk("abort_keep_ready", card_ready, 1);
        chk("abort_keep_index", cmd_index, 17);
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        tag = "abort_cmd0";
        send_cmd(6'd0, 32'd0, 8'h95);
        push(8'hFF); push(8'h01);
        rx_n(2);

        // Reset mid-DATA
        tag = "rst_setup";
        cmd1_x3();
        tag = "rst_read";
        send_cmd(6'd17, 32'h55, 8'hFF);
        push(8'hFF); push(8'h00); push(8'hFF); push(8'hFF); push(8'hFE);
        for (int k = 0; k < 11; k++) push(8'(k));
        rx_n(16);
        chk("rstmid_pre_miso", miso, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_miso", miso, 1);
        chk("rstmid_cmd_valid", cmd_valid, 0);
        chk("rstmid_cmd_index", cmd_index, 0);
        chk("rstmid_cmd_arg", cmd_arg, 0);
        chk("rstmid_card_ready", card_ready, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tag = "rstmid_cmd0";
        v0 = vld_cnt;
        send_cmd(6'd0, 32'd0, 8'h95);
        chk("rstmid_cmd0_pulse", vld_cnt - v0, 1);
        push(8'hFF); push(8'h01);
        rx_n(2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
